// File: rtl/gmii_rx_inband_status_pkg.sv
// gmii_rx_inband_status_pkg: speed codes, false-carrier code and FSM encoding for the GMII receive status monitor
package gmii_rx_inband_status_pkg;
   localparam logic [1:0] SPEED_10M     = 2'b00;
   localparam logic [1:0] SPEED_100M    = 2'b01;
   localparam logic [1:0] SPEED_1G      = 2'b10;
   localparam logic [7:0] FALSE_CARRIER = 8'h0E;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FRAME = 2'd1, S_ERR = 2'd2} rx_state_t;
   function automatic logic speed_ok(input logic [1:0] s);
      return s != 2'b11;
   endfunction
endpackage

// File: rtl/gmii_inband_filter.sv
// gmii_inband_filter: glitch filter for in-band status nibbles, pulses accept after FILTER_LEN matching idle samples
module gmii_inband_filter
   import gmii_rx_inband_status_pkg::*;
#(
   parameter int FILTER_LEN = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       idle,
   input  logic [3:0] sample,
   output logic       accept,
   output logic [3:0] cand
);
   logic       ok;
   logic [3:0] cnt, cnt_nxt;
   always_comb begin
      ok = idle && speed_ok(sample[2:1]);
      cnt_nxt = !ok ? 4'd0 : sample != cand ? 4'd1 : cnt == 4'(FILTER_LEN) ? cnt : cnt + 4'd1;
      accept = cnt_nxt == 4'(FILTER_LEN);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cand <= 4'h0;
         cnt <= 4'd0;
      end else begin
         if (ok) cand <= sample;
         cnt <= cnt_nxt;
      end
endmodule

// File: rtl/gmii_rx_inband_status.sv
// gmii_rx_inband_status: passive GMII receive monitor decoding in-band link status with change events and frame statistics
module gmii_rx_inband_status
   import gmii_rx_inband_status_pkg::*;
#(
   parameter int FILTER_LEN = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           gmii_rxd,
   input  logic                 gmii_rx_dv,
   input  logic                 gmii_rx_er,
   output logic                 link_up,
   output logic [1:0]           speed,
   output logic                 full_duplex,
   output logic                 status_valid,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [3:0]           evt_data,
   output logic                 evt_overflow,
   input  logic                 clear_counters,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] rx_error_count,
   output logic [CNT_WIDTH-1:0] false_carrier_count
);
   rx_state_t  state, state_nxt;
   logic       idle, fc, fc_q, accept, push, frame_start, frame_end;
   logic       armed, counted, err_acc;
   logic [3:0] cand;
   always_comb begin
      idle = !gmii_rx_dv && !gmii_rx_er;
      fc = !gmii_rx_dv && gmii_rx_er && gmii_rxd == FALSE_CARRIER;
      push = accept && (!status_valid || cand != {full_duplex, speed, link_up});
   end
   gmii_inband_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk    (clk),
      .rst_n  (rst_n),
      .idle   (idle),
      .sample (gmii_rxd[3:0]),
      .accept (accept),
      .cand   (cand)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nxt;
   always_comb state_nxt = gmii_rx_dv ? S_FRAME : gmii_rx_er ? S_ERR : S_IDLE;
   always_comb begin
      frame_start = gmii_rx_dv && state != S_FRAME;
      frame_end = !gmii_rx_dv && state == S_FRAME;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {full_duplex, speed, link_up} <= 4'h0;
         status_valid <= 1'b0;
         evt_valid <= 1'b0;
         evt_data <= 4'h0;
         evt_overflow <= 1'b0;
      end else begin
         if (push) begin
            {full_duplex, speed, link_up} <= cand;
            status_valid <= 1'b1;
            evt_data <= cand;
         end
         evt_valid <= push || (evt_valid && !evt_ready);
         evt_overflow <= !clear_counters && (evt_overflow || (push && evt_valid && !evt_ready));
      end
   // armed blocks counting a frame already in progress when reset is released
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         armed <= 1'b0;
         counted <= 1'b0;
         err_acc <= 1'b0;
         fc_q <= 1'b0;
         frame_count <= '0;
         rx_error_count <= '0;
         false_carrier_count <= '0;
      end else begin
         armed <= armed || !gmii_rx_dv;
         fc_q <= fc;
         if (frame_start) counted <= armed;
         if (gmii_rx_dv) err_acc <= (err_acc && !frame_start) || gmii_rx_er;
         frame_count <= clear_counters ? '0 :
            frame_count + CNT_WIDTH'(frame_start && armed && !(&frame_count));
         rx_error_count <= clear_counters ? '0 :
            rx_error_count + CNT_WIDTH'(frame_end && counted && err_acc && !(&rx_error_count));
         false_carrier_count <= clear_counters ? '0 :
            false_carrier_count + CNT_WIDTH'(fc && !fc_q && !(&false_carrier_count));
      end
endmodule

// File: tb/tb_gmii_rx_inband_status.sv
// tb_gmii_rx_inband_status: directed scenarios plus randomized stream checked against a stream-level reference model
module tb_gmii_rx_inband_status;
   localparam int FL = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;
   logic          clk = 1'b0, rst_n = 1'b0;
   logic [7:0]    gmii_rxd = 8'hDD;
   logic          gmii_rx_dv = 1'b0, gmii_rx_er = 1'b0, evt_ready = 1'b0, clear_counters = 1'b0;
   logic          link_up, full_duplex, status_valid, evt_valid, evt_overflow;
   logic [1:0]    speed;
   logic [3:0]    evt_data;
   logic [CW-1:0] frame_count, rx_error_count, false_carrier_count;
   int            n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   gmii_rx_inband_status #(.FILTER_LEN(FL), .CNT_WIDTH(CW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .gmii_rxd            (gmii_rxd),
      .gmii_rx_dv          (gmii_rx_dv),
      .gmii_rx_er          (gmii_rx_er),
      .link_up             (link_up),
      .speed               (speed),
      .full_duplex         (full_duplex),
      .status_valid        (status_valid),
      .evt_valid           (evt_valid),
      .evt_ready           (evt_ready),
      .evt_data            (evt_data),
      .evt_overflow        (evt_overflow),
      .clear_counters      (clear_counters),
      .frame_count         (frame_count),
      .rx_error_count      (rx_error_count),
      .false_carrier_count (false_carrier_count)
   );

   // Reference model: status accepted when the last FL cycles were all idle with the same legal nibble;
   // frames are dv rising edges seen after reset, errors judged per frame at its falling edge.
   int         hist[FL];
   logic [3:0] m_stat, m_evt_data;
   logic       m_sv, m_evt_valid, m_ovf, m_prev_dv, m_prev_fc, m_counted, m_ferr;
   int         m_frames, m_errs, m_fc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FL; i++) hist[i] = -1;
         m_stat = 4'h0; m_evt_data = 4'h0; m_sv = 0; m_evt_valid = 0; m_ovf = 0;
         m_prev_dv = 1; m_prev_fc = 0; m_counted = 0; m_ferr = 0;
         m_frames = 0; m_errs = 0; m_fc = 0;
      end else begin
         int   s;
         logic acc, fcv;
         s = (!gmii_rx_dv && !gmii_rx_er && gmii_rxd[2:1] != 2'b11) ? int'(gmii_rxd[3:0]) : -1;
         for (int i = FL - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = s;
         acc = s >= 0;
         for (int i = 0; i < FL; i++) if (hist[i] != s) acc = 0;
         if (acc && (!m_sv || s != int'(m_stat))) begin
            if (m_evt_valid && !evt_ready) m_ovf = 1;
            m_evt_valid = 1; m_evt_data = 4'(s); m_stat = 4'(s); m_sv = 1;
         end else if (m_evt_valid && evt_ready) m_evt_valid = 0;
         if (gmii_rx_dv && !m_prev_dv) begin
            m_counted = 1; m_ferr = gmii_rx_er;
            if (m_frames < CMAX) m_frames++;
         end else if (gmii_rx_dv) m_ferr = m_ferr | gmii_rx_er;
         if (!gmii_rx_dv && m_prev_dv) begin
            if (m_counted && m_ferr && m_errs < CMAX) m_errs++;
            m_counted = 0;
         end
         fcv = !gmii_rx_dv && gmii_rx_er && gmii_rxd == 8'h0E;
         if (fcv && !m_prev_fc && m_fc < CMAX) m_fc++;
         m_prev_fc = fcv;
         m_prev_dv = gmii_rx_dv;
         if (clear_counters) begin
            m_frames = 0; m_errs = 0; m_fc = 0; m_ovf = 0;
         end
      end
   end

   task automatic cyc(input logic dv, input logic er, input logic [7:0] d);
      gmii_rx_dv = dv; gmii_rx_er = er; gmii_rxd = d;
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_checks++; if ({link_up, speed, full_duplex, status_valid} !== 5'b0) begin n_fail++; $display("FAIL reset_status got %b exp 00000", {link_up, speed, full_duplex, status_valid}); end
      n_checks++; if ({evt_valid, evt_data, evt_overflow} !== 6'b0) begin n_fail++; $display("FAIL reset_evt got %b exp 000000", {evt_valid, evt_data, evt_overflow}); end
      n_checks++; if ({frame_count, rx_error_count, false_carrier_count} !== '0) begin n_fail++; $display("FAIL reset_counters got %h/%h/%h exp 0/0/0", frame_count, rx_error_count, false_carrier_count); end
      n_checks++; if (dut.u_filter.cnt !== 4'd0) begin n_fail++; $display("FAIL reset_filter_cnt got %0d exp 0", dut.u_filter.cnt); end
      rst_n = 1'b1;
   endtask

   task automatic test_acceptance;
      repeat (3) cyc(0, 0, 8'hDD);
      n_checks++; if ({status_valid, evt_valid} !== 2'b00) begin n_fail++; $display("FAIL accept_early got sv=%b ev=%b exp 0 0", status_valid, evt_valid); end
      cyc(0, 0, 8'hDD);
      n_checks++; if ({link_up, speed, full_duplex} !== {1'b1, 2'b10, 1'b1}) begin n_fail++; $display("FAIL accept_status got link=%b speed=%b dup=%b exp 1 10 1", link_up, speed, full_duplex); end
      n_checks++; if ({status_valid, evt_valid, evt_data} !== {1'b1, 1'b1, 4'hD}) begin n_fail++; $display("FAIL accept_evt got sv=%b ev=%b data=%h exp 1 1 d", status_valid, evt_valid, evt_data); end
   endtask

   task automatic test_glitch;
      evt_ready = 1'b1;
      cyc(0, 0, 8'hDD);
      evt_ready = 1'b0;
      n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_pop got %b exp 0", evt_valid); end
      repeat (3) cyc(0, 0, 8'h00);
      repeat (4) cyc(0, 0, 8'hDD);
      n_checks++; if ({link_up, speed, full_duplex, status_valid} !== 5'b11011) begin n_fail++; $display("FAIL glitch_status got %b exp 11011", {link_up, speed, full_duplex, status_valid}); end
      n_checks++; if ({evt_valid, evt_data} !== {1'b0, 4'hD}) begin n_fail++; $display("FAIL glitch_evt got ev=%b data=%h exp 0 d", evt_valid, evt_data); end
   endtask

   task automatic test_overflow;
      evt_ready = 1'b0;
      repeat (4) cyc(0, 0, 8'h0B);
      n_checks++; if ({evt_valid, evt_data, evt_overflow} !== {1'b1, 4'hB, 1'b0}) begin n_fail++; $display("FAIL ovf_first got ev=%b data=%h ovf=%b exp 1 b 0", evt_valid, evt_data, evt_overflow); end
      repeat (4) cyc(0, 0, 8'h03);
      n_checks++; if ({evt_valid, evt_data, evt_overflow} !== {1'b1, 4'h3, 1'b1}) begin n_fail++; $display("FAIL ovf_second got ev=%b data=%h ovf=%b exp 1 3 1", evt_valid, evt_data, evt_overflow); end
      n_checks++; if ({link_up, speed, full_duplex} !== 4'b1010) begin n_fail++; $display("FAIL ovf_status got %b exp 1010", {link_up, speed, full_duplex}); end
      evt_ready = 1'b1;
      cyc(0, 0, 8'h03);
      evt_ready = 1'b0;
      n_checks++; if ({evt_valid, evt_overflow} !== 2'b01) begin n_fail++; $display("FAIL ovf_pop got ev=%b ovf=%b exp 0 1", evt_valid, evt_overflow); end
   endtask

   task automatic test_errors;
      clear_counters = 1'b1;
      cyc(0, 0, 8'h33);
      clear_counters = 1'b0;
      n_checks++; if ({frame_count, rx_error_count, evt_overflow} !== '0) begin n_fail++; $display("FAIL err_clear got %h/%h ovf=%b exp 0/0 0", frame_count, rx_error_count, evt_overflow); end
      for (int i = 0; i < 64; i++) begin
         cyc(1, i == 10, 8'($urandom));
         if (i == 0) begin
            n_checks++; if (frame_count !== 4'd1) begin n_fail++; $display("FAIL err_frame_latency got %0d exp 1", frame_count); end
         end
      end
      cyc(0, 0, 8'h33);
      n_checks++; if (rx_error_count !== 4'd1) begin n_fail++; $display("FAIL err_latency got %0d exp 1", rx_error_count); end
      cyc(0, 0, 8'h33);
      for (int i = 0; i < 64; i++) cyc(1, 0, 8'($urandom));
      repeat (2) cyc(0, 0, 8'h33);
      n_checks++; if ({frame_count, rx_error_count} !== {4'd2, 4'd1}) begin n_fail++; $display("FAIL err_totals got %0d/%0d exp 2/1", frame_count, rx_error_count); end
   endtask

   task automatic test_false_carrier;
      clear_counters = 1'b1;
      cyc(0, 0, 8'h33);
      clear_counters = 1'b0;
      cyc(0, 1, 8'h0E);
      n_checks++; if (false_carrier_count !== 4'd1) begin n_fail++; $display("FAIL fc_latency got %0d exp 1", false_carrier_count); end
      repeat (2) cyc(0, 1, 8'h0E);
      n_checks++; if ({false_carrier_count, dut.u_filter.cnt} !== {4'd1, 4'd0}) begin n_fail++; $display("FAIL fc_run1 got cnt=%0d filt=%0d exp 1 0", false_carrier_count, dut.u_filter.cnt); end
      repeat (2) cyc(0, 0, 8'h33);
      repeat (3) cyc(0, 1, 8'h0E);
      n_checks++; if ({false_carrier_count, dut.u_filter.cnt} !== {4'd2, 4'd0}) begin n_fail++; $display("FAIL fc_run2 got cnt=%0d filt=%0d exp 2 0", false_carrier_count, dut.u_filter.cnt); end
      cyc(0, 0, 8'h33);
      repeat (3) cyc(0, 1, 8'h0F);
      n_checks++; if (dut.u_filter.cnt !== 4'd0) begin n_fail++; $display("FAIL fc_run3_filter got %0d exp 0", dut.u_filter.cnt); end
      cyc(0, 0, 8'h33);
      n_checks++; if (false_carrier_count !== 4'd2) begin n_fail++; $display("FAIL fc_total got %0d exp 2", false_carrier_count); end
   endtask

   task automatic test_saturation;
      clear_counters = 1'b1;
      cyc(0, 0, 8'h33);
      clear_counters = 1'b0;
      repeat (20) begin
         repeat (2) cyc(1, 0, 8'h55);
         cyc(0, 0, 8'h33);
      end
      n_checks++; if (frame_count !== 4'hF) begin n_fail++; $display("FAIL sat_frames got %h exp f", frame_count); end
      clear_counters = 1'b1;
      cyc(1, 0, 8'h55);
      clear_counters = 1'b0;
      n_checks++; if (frame_count !== 4'h0) begin n_fail++; $display("FAIL sat_clear got %h exp 0", frame_count); end
      cyc(1, 0, 8'h55);
      cyc(0, 0, 8'h33);
      n_checks++; if (frame_count !== 4'h0) begin n_fail++; $display("FAIL sat_after_clear got %h exp 0", frame_count); end
   endtask

   task automatic test_reset_mid;
      evt_ready = 1'b0;
      repeat (4) cyc(0, 0, 8'h05);
      repeat (3) cyc(1, 0, 8'hAA);
      n_checks++; if ({evt_valid, frame_count} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL midrst_setup got ev=%b frames=%0d exp 1 1", evt_valid, frame_count); end
      rst_n = 1'b0;
      #1;
      n_checks++; if ({link_up, speed, full_duplex, status_valid, evt_valid, evt_data, evt_overflow} !== 11'b0) begin n_fail++; $display("FAIL midrst_outputs got %b exp 0", {link_up, speed, full_duplex, status_valid, evt_valid, evt_data, evt_overflow}); end
      n_checks++; if ({frame_count, rx_error_count, false_carrier_count} !== '0) begin n_fail++; $display("FAIL midrst_counters got %h/%h/%h exp 0/0/0", frame_count, rx_error_count, false_carrier_count); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) cyc(1, 1, 8'hAA);
      cyc(0, 0, 8'h33);
      n_checks++; if ({frame_count, rx_error_count} !== 8'h00) begin n_fail++; $display("FAIL midrst_inflight got %0d/%0d exp 0/0", frame_count, rx_error_count); end
      repeat (2) cyc(1, 0, 8'hAA);
      cyc(0, 0, 8'h33);
      n_checks++; if (frame_count !== 4'd1) begin n_fail++; $display("FAIL midrst_next_frame got %0d exp 1", frame_count); end
   endtask

   task automatic test_random;
      logic [7:0] picks[6] = '{8'hDD, 8'h33, 8'h0B, 8'h07, 8'h05, 8'hF8};
      logic       dv = 0, er = 0;
      logic [7:0] d = 8'h33;
      int         kind = 0, len = 0;
      for (int c = 0; c < 800; c++) begin
         if (len == 0) begin
            len = $urandom_range(1, 9);
            kind = $urandom_range(0, 5);
            d = picks[$urandom_range(0, 5)];
         end
         len--;
         dv = kind == 3;
         er = kind == 3 ? $urandom_range(0, 15) == 0 : kind >= 4;
         if (kind == 4) d = 8'h0E;
         if (kind == 3) d = 8'($urandom);
         evt_ready = $urandom_range(0, 3) == 0;
         clear_counters = $urandom_range(0, 79) == 0;
         cyc(dv, er, d);
         n_checks++; if ({full_duplex, speed, link_up, status_valid} !== {m_stat, m_sv}) begin n_fail++; $display("FAIL rand_status cycle %0d got %b exp %b", c, {full_duplex, speed, link_up, status_valid}, {m_stat, m_sv}); end
         n_checks++; if ({evt_valid, evt_data, evt_overflow} !== {m_evt_valid, m_evt_data, m_ovf}) begin n_fail++; $display("FAIL rand_evt cycle %0d got %b exp %b", c, {evt_valid, evt_data, evt_overflow}, {m_evt_valid, m_evt_data, m_ovf}); end
         n_checks++; if ({frame_count, rx_error_count} !== {CW'(m_frames), CW'(m_errs)}) begin n_fail++; $display("FAIL rand_frames cycle %0d got %0d/%0d exp %0d/%0d", c, frame_count, rx_error_count, m_frames, m_errs); end
         n_checks++; if (false_carrier_count !== CW'(m_fc)) begin n_fail++; $display("FAIL rand_fc cycle %0d got %0d exp %0d", c, false_carrier_count, m_fc); end
      end
      evt_ready = 1'b0;
      clear_counters = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_acceptance;
      test_glitch;
      test_overflow;
      test_errors;
      test_false_carrier;
      test_saturation;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/gmii_rx_inband_status.md
# gmii_rx_inband_status

Receive-side status monitor that sits directly downstream of the RGMII PHY interface, in the `gmii_rx_clk` domain alongside the MAC receive path. It passively observes the GMII receive bus and decodes RGMII in-band link status (link, speed, duplex) from inter-frame idle. It filters that status against glitches, reports changes through a single-entry valid/ready event port, and keeps saturating counters for frames, errored frames and false-carrier events.

## Interface
Parameters:
- `FILTER_LEN`, default 4: consecutive identical idle status samples required before acceptance. Legal range 2..15.
- `CNT_WIDTH`, default 16: width of each statistics counter.

Ports:
- `clk`, input, 1: receive clock, which is the GMII receive clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `gmii_rxd`, input, 8: receive data.
- `gmii_rx_dv`, input, 1: receive data valid.
- `gmii_rx_er`, input, 1: receive error.
- `link_up`, output, 1: accepted link status.
- `speed`, output, 2: accepted speed. 2'b00 = 10M, 2'b01 = 100M, 2'b10 = 1G.
- `full_duplex`, output, 1: accepted duplex.
- `status_valid`, output, 1: set once the first status has been accepted since reset.
- `evt_valid`, output, 1: status-change event pending.
- `evt_ready`, input, 1: consumer accepts the event.
- `evt_data`, output, 4: {duplex, speed[1:0], link} of the event.
- `evt_overflow`, output, 1: sticky flag; an event was overwritten before it was consumed.
- `clear_counters`, input, 1: synchronous clear of all counters and of `evt_overflow`.
- `frame_count`, output, CNT_WIDTH: frames seen.
- `rx_error_count`, output, CNT_WIDTH: frames that contained at least one error.
- `false_carrier_count`, output, CNT_WIDTH: false-carrier events.

## Operation
- **Cycle classes:**
  - IDLE: dv=0, er=0.
  - FRAME: dv=1.
  - FALSE_CARRIER: dv=0, er=1, rxd=8'h0E.
  - OTHER_ER: dv=0, er=1, any other rxd. This covers carrier extension and carrier sense; such cycles are not counted.
- **FSM states:**
  - S_IDLE: leaves on dv=1 to S_FRAME, or on er=1 to S_ERR.
  - S_FRAME: on dv=0 goes to S_IDLE or S_ERR according to er.
  - S_ERR: on dv=1 goes to S_FRAME; on dv=0, er=0 goes to S_IDLE.
- **In-band sample:** taken from rxd[3:0] in IDLE cycles only. Bit 0 is link, bits 2:1 are speed, bit 3 is duplex. rxd[7:4] is ignored.
- **Filter:**
  - Holds a candidate nibble and a match count.
  - When an IDLE sample equals the candidate, the count increments, saturating at FILTER_LEN.
  - When an IDLE sample differs, the candidate is loaded with the sample and the count is set to 1.
  - Any non-IDLE cycle sets the count to 0.
  - The candidate is accepted when the count reaches FILTER_LEN.
- **Accept:**
  - If `status_valid`=0, or the candidate differs from the current status, the outputs update, `status_valid` is set, and an event is pushed.
  - Re-acceptance of an identical value does nothing.
  - Speed code 2'b11 is never accepted: it is treated as a non-matching sample, so the count is set to 0.
- **Event buffer:**
  - Single entry.
  - A push while empty, or a push in the same cycle as a pop (`evt_valid` & `evt_ready`), loads the entry with `evt_valid`=1.
  - A push while full and not popped overwrites `evt_data` with the newest value and sets `evt_overflow`.
  - `evt_data` is stable while `evt_valid`=1 and `evt_ready`=0, unless it is overwritten.
- **Counters:**
  - `frame_count` increments on the S_IDLE/S_ERR → S_FRAME transition.
  - `rx_error_count` increments once per frame, on the frame-end transition, if er=1 on any cycle of that frame.
  - `false_carrier_count` increments on the first FALSE_CARRIER cycle of each contiguous run.
  - All counters saturate at all-ones.
  - `clear_counters` takes priority over any same-cycle increment.

## Timing
- All outputs are registered.
- Reset values:
  - `link_up`, `speed`, `full_duplex`, `status_valid`, `evt_valid`, `evt_overflow`: 0.
  - `evt_data`: 4'h0.
  - All counters: 0.
  - FSM: S_IDLE. Filter count: 0.
- Status latency: outputs and `evt_valid` update in the cycle after the FILTER_LEN-th matching IDLE sample.
- `frame_count` updates the cycle after the first dv=1 cycle.
- `rx_error_count` updates the cycle after the first dv=0 cycle.
- `false_carrier_count` updates the cycle after the first 0x0E cycle.
- Asserting `rst_n` low mid-frame or with an event pending returns every register to its reset value immediately.
- After reset, the first frame in progress is counted only if a dv rising edge is seen after reset is released.

## Structure
- Shared header/package holds:
  - speed codes (SPEED_10M/100M/1G);
  - the false-carrier code 8'h0E;
  - the FSM state encodings (2 bits).
- Sub-module `gmii_inband_filter` contains the candidate, match count and acceptance pulse, parameterised by FILTER_LEN.
- The top level holds the FSM, the event buffer and the counters.

## Test plan
1. Status acceptance, FILTER_LEN=4:
   - Stimulus: 4 IDLE cycles with rxd=8'hDD after reset.
   - Response: the next cycle shows `link_up`=1, `speed`=2'b10, `full_duplex`=1, `status_valid`=1, `evt_valid`=1, `evt_data`=4'hD.
2. Glitch rejection:
   - Stimulus: with 1G/full/up accepted, send 3 IDLE cycles of rxd=8'h00 and then 8'hDD again.
   - Response: no output change and no event.
3. Event overflow:
   - Stimulus: hold `evt_ready`=0; accept 4'hB, then 4'h3.
   - Response: `evt_data`=4'h3, `evt_overflow`=1. One cycle with `evt_ready`=1 then gives `evt_valid`=0.
4. Error counting:
   - Stimulus: a 64-cycle frame with er=1 on cycle 10, then a clean 64-cycle frame.
   - Response: `frame_count`=2, `rx_error_count`=1.
5. False carrier:
   - Stimulus: two runs of dv=0, er=1, rxd=8'h0E (3 cycles each) separated by IDLE, plus one run with rxd=8'h0F.
   - Response: `false_carrier_count`=2. The filter count is 0 after each run.
6. Boundaries:
   - Counters: with CNT_WIDTH=4, run 20 frames → `frame_count`=4'hF. `clear_counters` asserted in the same cycle as a frame start → 0.
   - Reset: `rst_n` low mid-frame → all outputs 0.
